serial_tx: RTL and testbench
============================

# serial_tx

Per-output-port serializer. It sits directly downstream of the router's routing/arbitration stage. It accepts one parallel flit when that stage asserts the port's enable, then shifts the flit onto a 1-bit link, LSB first, followed by an even-parity bit and one idle gap cycle. While it is shifting, or while the far end signals backpressure, it holds `busy` high; this is the same `busy` the arbitration stage uses to gate grants, reads and enables. Five instances exist per router: N, E, S, W and L.

## Interface
- `WIDTH`, default `` `PAYLOAD_SIZE+`ADDR_SZ ``: flit width in bits. It must be at least 2.
- `CNT_W`, default 16: width of the sent-flit statistics counter.

- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `item_in`  in  WIDTH  flit from the crossbar. Valid only in the cycle where `ena`=1.
- `ena`  in  1  load strobe from the routing/arbitration stage.
- `busy`  out  1  the block cannot accept a flit this cycle.
- `rx_full`  in  1  backpressure level from the far-end receiver, synchronous to `clk`.
- `tx_data`  out  1  serial data bit.
- `tx_valid`  out  1  high during the data and parity bits of a frame.
- `flit_cnt`  out  CNT_W  count of completed frames. Wraps modulo 2^CNT_W.

## Operation
- The FSM has four states: IDLE, SHIFT, PARITY and GAP.
- IDLE:
  - If `ena`=1 and `busy`=0, load `item_in` into the shift register, clear `bit_cnt` to 0, clear the parity accumulator to 0, and go to SHIFT.
  - `ena` while `busy`=1 is ignored, with no state change.
- SHIFT:
  - Drive `tx_data`=sreg[0] and `tx_valid`=1.
  - Each cycle, shift sreg right, XOR the outgoing bit into parity, and increment `bit_cnt`.
  - When `bit_cnt`==WIDTH-1, go to PARITY.
- PARITY: drive `tx_data`=parity accumulator (even parity over the WIDTH data bits) and `tx_valid`=1. Go to GAP.
- GAP:
  - Drive `tx_valid`=0 and `tx_data`=0.
  - Increment `flit_cnt`, wrapping from 2^CNT_W-1 to 0.
  - Go to IDLE.
- `busy` = (state≠IDLE) | rx_full_q, where rx_full_q is `rx_full` registered by one flop.
  - `busy` is purely registered. There is no combinational path from `ena` or `item_in` to `busy`.
- `rx_full` asserting mid-frame does not abort the frame. The frame completes, and `busy` stays high afterwards while rx_full_q=1.
- `tx_data` is 0 whenever `tx_valid`=0.
- Reset values, applied immediately and asynchronously:
  - state=IDLE, sreg=0, `bit_cnt`=0, parity=0.
  - rx_full_q=0, `flit_cnt`=0.
  - Therefore `busy`=0, `tx_valid`=0, `tx_data`=0.
- Reset asserted mid-frame truncates the frame. `tx_valid` drops without any clock edge. The far end discards partial frames on `tx_valid` falling before the parity bit.

## Timing
- Accept at edge 0, meaning `ena`=1 and `busy`=0 are sampled there.
- Cycles after edge 0:
  - Cycles 1..WIDTH: data bits 0..WIDTH-1.
  - Cycle WIDTH+1: parity.
  - Cycle WIDTH+2: gap.
  - Cycle WIDTH+3: IDLE, `busy`=0 (if rx_full_q=0). The next flit can be accepted at the end of this cycle.
- Throughput: one flit per WIDTH+3 cycles.
- `busy` rises in the cycle after acceptance. This is compatible with arbitration, which grants at most once per `busy`-low cycle.
- `rx_full` to `busy`: 1 cycle latency.
  - If `rx_full` rises in the same cycle as an accepted `ena`, the flit is still taken.
- `flit_cnt` updates on the edge that leaves GAP.

## Structure
- `PAYLOAD_SIZE` and `ADDR_SZ` come from the shared global defines header.
- FSM state encodings (2-bit) are added to that header as `SER_IDLE`, `SER_SHIFT`, `SER_PARITY`, `SER_GAP`, so the matching `serial_rx` decodes the same framing constants.
- No sub-module: a single module with the FSM, shift register, `$clog2(WIDTH)`-bit `bit_cnt`, parity flop and statistics counter.

## Test plan
All cases use WIDTH=16.
- Reset mid-frame: `reset`=0 at cycle 6 → `tx_valid`, `tx_data`, `busy` = 0 immediately. `flit_cnt` unchanged at 0. After release, a new `ena` is accepted normally.
- Basic frame: load 0xA5C3 → `tx_data` over cycles 1..16 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. Parity bit in cycle 17 = 0. Gap in cycle 18 with `tx_valid`=0. `busy` low at cycle 19. `flit_cnt`=1.
- Odd parity input: load 0x0001 → bits 1 then fifteen 0s. Parity bit = 1.
- Back-to-back: `ena` held high with 0x1234 then 0x8000 → second frame's first bit appears at cycle 20. The `ena` pulses during cycles 1..18 cause no reload.
- Backpressure: `rx_full`=1 at cycle 5 of a frame → the frame completes through cycle 18. `busy` stays 1 until 1 cycle after `rx_full` falls. `ena` pulses in that window are ignored.
- Counter wrap: CNT_W=4, send 17 frames → `flit_cnt` reads 15 after frame 15, 0 after frame 16, 1 after frame 17.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared framing constants for the serial link: flit sizing and the 2-bit
// frame-state encodings that both serial_tx and serial_rx decode.
package serial_tx_pkg;

  localparam int PAYLOAD_SIZE = 12;
  localparam int ADDR_SZ      = 4;

  typedef logic [1:0] ser_state_t;

  localparam logic [1:0] SER_IDLE   = 2'd0;
  localparam logic [1:0] SER_SHIFT  = 2'd1;
  localparam logic [1:0] SER_PARITY = 2'd2;
  localparam logic [1:0] SER_GAP    = 2'd3;

endpackage

// File: rtl/serial_tx.sv
// Per-output-port serializer: loads one flit, sends it LSB first on a 1-bit
// link, then an even-parity bit and one idle gap cycle.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_SIZE + ADDR_SZ,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] item_in,
  input  logic             ena,
  output logic             busy,
  input  logic             rx_full,
  output logic             tx_data,
  output logic             tx_valid,
  output logic [CNT_W-1:0] flit_cnt,
  output ser_state_t       state_dbg
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic             parity;
  logic             rx_full_q;

  // Handshake: a flit is taken on the edge where ena=1 and busy=0; busy is
  // built only from flops so the arbiter sees no path from ena back to busy.
  assign busy = (state != SER_IDLE) | rx_full_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SER_IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      rx_full_q <= 1'b0;
      flit_cnt  <= '0;
    end else begin
      rx_full_q <= rx_full;
      case (state)
        SER_IDLE: begin
          if (ena && !busy) begin
            sreg    <= item_in;
            bit_cnt <= '0;
            parity  <= 1'b0;
            state   <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          sreg    <= sreg >> 1;
          parity  <= parity ^ sreg[0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= SER_PARITY;
        end
        SER_PARITY: state <= SER_GAP;
        SER_GAP: begin
          flit_cnt <= flit_cnt + 1'b1;
          state    <= SER_IDLE;
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

  // Outputs decode the state directly so a reset drops tx_valid at once.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    case (state)
      SER_SHIFT: begin
        tx_valid = 1'b1;
        tx_data  = sreg[0];
      end
      SER_PARITY: begin
        tx_valid = 1'b1;
        tx_data  = parity;
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed flits with hand-computed frames pushed to a
// queue, a negedge monitor reassembling frames, plus cycle-exact checks.
module tb_serial_tx;
  import serial_tx_pkg::*;

  localparam int W  = 16;
  localparam int FW = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ena = 1'b0;
  logic         rx_full = 1'b0;
  logic [W-1:0] item_in = '0;

  logic         busy, tx_data, tx_valid;
  logic [15:0]  flit_cnt;
  ser_state_t   state_dbg;
  logic         busy_w, tx_data_w, tx_valid_w;
  logic [3:0]   flit_cnt_w;
  ser_state_t   state_dbg_w;

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;
  logic [FW-1:0] exp_q[$];

  serial_tx #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .item_in(item_in), .ena(ena), .busy(busy),
    .rx_full(rx_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .flit_cnt(flit_cnt), .state_dbg(state_dbg)
  );

  serial_tx #(.WIDTH(W), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .item_in(item_in), .ena(ena), .busy(busy_w),
    .rx_full(rx_full), .tx_data(tx_data_w), .tx_valid(tx_valid_w),
    .flit_cnt(flit_cnt_w), .state_dbg(state_dbg_w)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: reassemble frames on tx_valid, compare when tx_valid falls
  logic [FW-1:0] frame = '0;
  int nbits = 0;
  always @(negedge clk) begin
    if (tx_valid) begin
      if (nbits < FW) frame[nbits] = tx_data;
      nbits++;
    end else begin
      check("idle_data_zero", {31'd0, tx_data}, 32'd0);
      if (nbits > 0) begin
        if (!reset) begin
          frame = '0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected none", frame);
        end else begin
          logic [FW-1:0] e;
          e = exp_q.pop_front();
          check("frame_len", nbits, FW);
          check("frame", {15'd0, frame}, {15'd0, e});
        end
        nbits = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got busy=%0b expected 0 within 200 cycles", busy);
    end
  endtask

  task automatic accept(input logic [W-1:0] d);
    wait_ready();
    #2 ena = 1'b1;
    item_in = d;
    @(posedge clk);
    #1 ena = 1'b0;
    item_in = W'($urandom_range(0, 65535));
    cur_cyc = 0;
  endtask

  task automatic to_cycle(input int n);
    while (cur_cyc < n) begin
      @(negedge clk);
      cur_cyc++;
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {31'd0, tx_data}, 32'd0);
    check("rst_flit_cnt", {16'd0, flit_cnt}, 32'd0);
    #2 reset = 1'b1;

    // reset mid-frame truncates immediately
    accept(16'hFFFF);
    to_cycle(6);
    check("mid_tx_valid_pre", {31'd0, tx_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_tx_data", {31'd0, tx_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_flit_cnt", {16'd0, flit_cnt}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg}, {30'd0, SER_IDLE});
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // basic frame 0xA5C3, even parity 0
    exp_q.push_back(17'h0A5C3);
    accept(16'hA5C3);
    to_cycle(1);
    check("basic_busy_c1", {31'd0, busy}, 32'd1);
    check("basic_valid_c1", {31'd0, tx_valid}, 32'd1);
    check("basic_bit0", {31'd0, tx_data}, 32'd1);
    to_cycle(17);
    check("basic_valid_c17", {31'd0, tx_valid}, 32'd1);
    check("basic_parity", {31'd0, tx_data}, 32'd0);
    to_cycle(18);
    check("basic_gap_valid", {31'd0, tx_valid}, 32'd0);
    check("basic_gap_busy", {31'd0, busy}, 32'd1);
    check("basic_cnt_c18", {16'd0, flit_cnt}, 32'd0);
    to_cycle(19);
    check("basic_busy_c19", {31'd0, busy}, 32'd0);
    check("basic_cnt_c19", {16'd0, flit_cnt}, 32'd1);
    check("basic_cnt_w", {28'd0, flit_cnt_w}, 32'd1);

    // odd-weight input, parity 1
    exp_q.push_back(17'h10001);
    accept(16'h0001);
    to_cycle(17);
    check("odd_parity", {31'd0, tx_data}, 32'd1);
    to_cycle(19);
    check("odd_cnt", {16'd0, flit_cnt}, 32'd2);

    // back-to-back with ena held high
    exp_q.push_back(17'h11234);
    exp_q.push_back(17'h18000);
    wait_ready();
    #2 ena = 1'b1;
    item_in = 16'h1234;
    @(posedge clk);
    #1 item_in = 16'h8000;
    cur_cyc = 0;
    to_cycle(18);
    check("b2b_busy_c18", {31'd0, busy}, 32'd1);
    to_cycle(19);
    check("b2b_busy_c19", {31'd0, busy}, 32'd0);
    check("b2b_valid_c19", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1 ena = 1'b0;
    to_cycle(20);
    check("b2b_valid_c20", {31'd0, tx_valid}, 32'd1);
    check("b2b_bit0_c20", {31'd0, tx_data}, 32'd0);
    to_cycle(38);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);
    check("b2b_cnt", {16'd0, flit_cnt}, 32'd4);

    // backpressure mid-frame, ena pulses ignored while busy
    exp_q.push_back(17'h000FF);
    accept(16'h00FF);
    to_cycle(5);
    rx_full = 1'b1;
    ena = 1'b1;
    item_in = 16'hFFFF;
    to_cycle(17);
    check("bp_parity_valid", {31'd0, tx_valid}, 32'd1);
    to_cycle(18);
    check("bp_gap_valid", {31'd0, tx_valid}, 32'd0);
    to_cycle(24);
    check("bp_busy_c24", {31'd0, busy}, 32'd1);
    check("bp_cnt", {16'd0, flit_cnt}, 32'd5);
    to_cycle(25);
    check("bp_busy_c25", {31'd0, busy}, 32'd1);
    rx_full = 1'b0;
    ena = 1'b0;
    to_cycle(26);
    check("bp_busy_c26", {31'd0, busy}, 32'd0);
    check("bp_state_c26", {30'd0, state_dbg}, {30'd0, SER_IDLE});
    to_cycle(27);
    check("bp_valid_c27", {31'd0, tx_valid}, 32'd0);

    // rx_full rising with an accepted ena: flit still taken
    exp_q.push_back(17'h00F0F);
    wait_ready();
    #2 ena = 1'b1;
    rx_full = 1'b1;
    item_in = 16'h0F0F;
    @(posedge clk);
    #1 ena = 1'b0;
    cur_cyc = 0;
    to_cycle(1);
    check("same_valid_c1", {31'd0, tx_valid}, 32'd1);
    check("same_busy_c1", {31'd0, busy}, 32'd1);
    rx_full = 1'b0;
    to_cycle(19);
    check("same_busy_c19", {31'd0, busy}, 32'd0);
    check("same_cnt", {16'd0, flit_cnt}, 32'd6);

    // counter wrap on the CNT_W=4 instance
    for (int k = 7; k <= 17; k++) begin
      logic [W-1:0] d;
      d = W'(k * 32'h1357);
      exp_q.push_back({^d, d});
      accept(d);
      to_cycle(19);
      check("wrap_cnt16", {16'd0, flit_cnt}, k);
      check("wrap_cnt4", {28'd0, flit_cnt_w}, k % 16);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
